// File: rtl/multicycle_mem_responder.sv
// Memory-side responder for the multicycle core's unified port.
// Word-organised storage with lane steering, extension and wait states.
module multicycle_mem_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    input  logic        mem_read_enable,
    input  logic        mem_write_enable,
    input  logic [2:0]  mem_format,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_misaligned
);

    localparam int WORDS = 1 << (ADDR_WIDTH - 2);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic [1:0]            state;
    logic [3:0]            count;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            fmt_q;
    logic                  write_q;
    logic                  both_q;
    logic [31:0]           read_data_q;
    logic                  misaligned_q;

    logic [31:0] storage [WORDS];

    logic                  accept;
    logic                  exec;
    logic                  err;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [31:0]           word;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [3:0]            lane_we;
    logic [31:0]           lane_wdata;
    logic [31:0]           merged_word;
    logic [31:0]           load_value;
    logic                  unused_addr_bits;

    // Bits above the decoded range are dropped so addresses wrap.
    assign unused_addr_bits = ^mem_address[31:ADDR_WIDTH];

    assign accept   = mem_read_enable | mem_write_enable;
    assign exec     = (state == WAIT) && (count == 4'd0);
    assign word_idx = addr_q[ADDR_WIDTH-1:2];
    assign word     = storage[word_idx];

    assign mem_ready      = (state == RESPOND);
    assign mem_read_data  = read_data_q;
    assign mem_misaligned = misaligned_q;

    // Format decode: alignment check, lane enables and load extension.
    always_comb begin
        err        = 1'b0;
        lane_we    = 4'b0000;
        lane_wdata = 32'd0;
        load_value = 32'd0;
        sel_byte   = word[{addr_q[1:0], 3'b000} +: 8];
        sel_half   = addr_q[1] ? word[31:16] : word[15:0];
        unique case (fmt_q)
            F_B: begin
                lane_we    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
                load_value = {{24{sel_byte[7]}}, sel_byte};
            end
            F_BU: begin
                lane_we    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
                load_value = {24'd0, sel_byte};
            end
            F_H: begin
                err        = addr_q[0];
                lane_we    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
                load_value = {{16{sel_half[15]}}, sel_half};
            end
            F_HU: begin
                err        = addr_q[0];
                lane_we    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
                load_value = {16'd0, sel_half};
            end
            F_W: begin
                err        = |addr_q[1:0];
                lane_we    = 4'b1111;
                lane_wdata = wdata_q;
                load_value = word;
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

    // Merge enabled lanes of the store into the current word.
    always_comb begin
        merged_word = word;
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                merged_word[8*i +: 8] = lane_wdata[8*i +: 8];
            end
        end
    end

    // Storage is deliberately not reset; contents survive reset.
    always_ff @(posedge clock) begin
        if (exec && write_q && !err) begin
            storage[word_idx] <= merged_word;
        end
    end

    // Control FSM: accept, count wait states, execute, respond.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            fmt_q        <= 3'd0;
            write_q      <= 1'b0;
            both_q       <= 1'b0;
            read_data_q  <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= mem_address[ADDR_WIDTH-1:0];
                        wdata_q <= mem_write_data;
                        fmt_q   <= mem_format;
                        write_q <= mem_write_enable;
                        both_q  <= mem_write_enable & mem_read_enable;
                        count   <= 4'(WAIT_STATES);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state        <= RESPOND;
                        misaligned_q <= err;
                        if (err || both_q) begin
                            read_data_q <= 32'd0;
                        end else if (!write_q) begin
                            read_data_q <= load_value;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESPOND: begin
                    state        <= IDLE;
                    misaligned_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Directed self-checking bench for multicycle_mem_responder.
// Instances with one and zero wait states share address/data/reset.
module tb_multicycle_mem_responder;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_address = 32'd0;
    logic [31:0] mem_write_data = 32'd0;
    logic [2:0]  mem_format = 3'd0;
    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] rdata1, rdata0;
    logic        ready1, ready0;
    logic        mis1, mis0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    multicycle_mem_responder #(.ADDR_WIDTH(16), .WAIT_STATES(1)) dut (
        .clock(clock), .reset(reset),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_enable(rd1), .mem_write_enable(wr1),
        .mem_format(mem_format), .mem_read_data(rdata1),
        .mem_ready(ready1), .mem_misaligned(mis1)
    );

    multicycle_mem_responder #(.ADDR_WIDTH(16), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_enable(rd0), .mem_write_enable(wr0),
        .mem_format(mem_format), .mem_read_data(rdata0),
        .mem_ready(ready0), .mem_misaligned(mis0)
    );

    // Issue one request and measure cycles from acceptance to ready.
    task automatic do_req(input bit use0, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] fmt, output logic [31:0] rdata,
                          output logic mis, output int lat);
        repeat (2) @(negedge clock);
        mem_address    = addr;
        mem_write_data = wdata;
        mem_format     = fmt;
        if (use0) begin rd0 = rd; wr0 = wr; end
        else begin rd1 = rd; wr1 = wr; end
        @(posedge clock);
        @(negedge clock);
        rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
        lat = -1; rdata = 32'd0; mis = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (use0 ? ready0 : ready1) begin
                lat   = c;
                rdata = use0 ? rdata0 : rdata1;
                mis   = use0 ? mis0 : mis1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (ready1 !== 1'b0 || mis1 !== 1'b0 || rdata1 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_ws1: got rdy=%b mis=%b data=%h expected 0 0 0",
                     ready1, mis1, rdata1);
        end
        n_checks++;
        if (ready0 !== 1'b0 || mis0 !== 1'b0 || rdata0 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_ws0: got rdy=%b mis=%b data=%h expected 0 0 0",
                     ready0, mis0, rdata0);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] d; logic m; int lat;
        do_req(0, 0, 1, 32'h100, 32'hDEADBEEF, F_W, d, m, lat);
        n_checks++;
        if (lat !== 2 || m !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_latency: got lat=%0d mis=%b expected 2 0", lat, m);
        end
        do_req(0, 1, 0, 32'h100, 32'h0, F_W, d, m, lat);
        n_checks++;
        if (lat !== 2 || d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_word: got lat=%0d data=%h expected 2 deadbeef", lat, d);
        end
        @(posedge clock); #1;
        n_checks++;
        if (ready1 !== 1'b0 || rdata1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL ready_pulse: got rdy=%b data=%h expected 0 deadbeef",
                     ready1, rdata1);
        end
    endtask

    task automatic test_subword_reads;
        logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h100, 32'h102};
        logic [2:0]  fmts  [4] = '{F_B, F_BU, F_H, F_HU};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE,
                                   32'hFFFFBEEF, 32'h0000DEAD};
        logic [31:0] d; logic m; int lat;
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1, 0, addrs[i], 32'h0, fmts[i], d, m, lat);
            n_checks++;
            if (lat !== 2 || m !== 1'b0 || d !== exps[i]) begin
                n_fail++;
                $display("FAIL subword_%0d: got lat=%0d mis=%b data=%h expected 2 0 %h",
                         i, lat, m, d, exps[i]);
            end
        end
    endtask

    task automatic test_partial_writes;
        logic [31:0] d; logic m; int lat;
        do_req(0, 0, 1, 32'h101, 32'hFFFFFF12, F_B, d, m, lat);
        n_checks++;
        if (lat !== 2 || d !== 32'h0000DEAD) begin
            n_fail++;
            $display("FAIL sb_holds_data: got lat=%0d data=%h expected 2 0000dead", lat, d);
        end
        do_req(0, 1, 0, 32'h100, 32'h0, F_W, d, m, lat);
        n_checks++;
        if (d !== 32'hDEAD12EF) begin
            n_fail++;
            $display("FAIL sb_merge: got %h expected dead12ef", d);
        end
        do_req(0, 0, 1, 32'h102, 32'hABCD5678, F_H, d, m, lat);
        do_req(0, 1, 0, 32'h100, 32'h0, F_W, d, m, lat);
        n_checks++;
        if (d !== 32'h567812EF) begin
            n_fail++;
            $display("FAIL sh_merge: got %h expected 567812ef", d);
        end
    endtask

    task automatic test_errors;
        logic [31:0] addrs [3] = '{32'h102, 32'h101, 32'h100};
        logic [2:0]  fmts  [3] = '{F_W, F_H, 3'b011};
        logic        wrs   [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] d; logic m; int lat;
        for (int i = 0; i < 3; i++) begin
            do_req(0, ~wrs[i], wrs[i], addrs[i], 32'hFFFFFFFF, fmts[i], d, m, lat);
            n_checks++;
            if (lat !== 2 || m !== 1'b1 || d !== 32'd0) begin
                n_fail++;
                $display("FAIL err_%0d: got lat=%0d mis=%b data=%h expected 2 1 0",
                         i, lat, m, d);
            end
            @(posedge clock); #1;
            n_checks++;
            if (mis1 !== 1'b0) begin
                n_fail++;
                $display("FAIL err_clear_%0d: got mis=%b expected 0", i, mis1);
            end
        end
        do_req(0, 1, 0, 32'h100, 32'h0, F_W, d, m, lat);
        n_checks++;
        if (m !== 1'b0 || d !== 32'h567812EF) begin
            n_fail++;
            $display("FAIL err_no_write: got mis=%b data=%h expected 0 567812ef", m, d);
        end
    endtask

    task automatic test_wrap_and_both;
        logic [31:0] d; logic m; int lat;
        do_req(0, 0, 1, 32'h10004, 32'h11111111, F_W, d, m, lat);
        do_req(0, 1, 0, 32'h4, 32'h0, F_W, d, m, lat);
        n_checks++;
        if (d !== 32'h11111111) begin
            n_fail++;
            $display("FAIL addr_wrap: got %h expected 11111111", d);
        end
        do_req(0, 1, 1, 32'h8, 32'h22, F_W, d, m, lat);
        n_checks++;
        if (lat !== 2 || m !== 1'b0 || d !== 32'd0) begin
            n_fail++;
            $display("FAIL both_en_resp: got lat=%0d mis=%b data=%h expected 2 0 0",
                     lat, m, d);
        end
        do_req(0, 1, 0, 32'h8, 32'h0, F_W, d, m, lat);
        n_checks++;
        if (d !== 32'h00000022) begin
            n_fail++;
            $display("FAIL both_en_write: got %h expected 00000022", d);
        end
    endtask

    // Reset pulse while a store waits; the store must never land.
    task automatic abort_store(input bit use0, input logic [31:0] addr);
        repeat (2) @(negedge clock);
        mem_address    = addr;
        mem_write_data = 32'hAAAAAAAA;
        mem_format     = F_W;
        if (use0) wr0 = 1'b1; else wr1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wr0 = 1'b0; wr1 = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            n_checks++;
            if ((use0 ? ready0 : ready1) !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_ready_%0d: got 1 expected 0", c);
            end
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset_abort;
        logic [31:0] d; logic m; int lat;
        do_req(0, 0, 1, 32'h20, 32'h13572468, F_W, d, m, lat);
        abort_store(0, 32'h20);
        do_req(0, 1, 0, 32'h20, 32'h0, F_W, d, m, lat);
        n_checks++;
        if (d !== 32'h13572468) begin
            n_fail++;
            $display("FAIL abort_ws1: got %h expected 13572468", d);
        end
        repeat (2) @(negedge clock);
        mem_address    = 32'h24;
        mem_write_data = 32'h0BADF00D;
        mem_format     = F_W;
        wr1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wr1 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL respond_ready: got %b expected 1", ready1);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL respond_reset_drop: got %b expected 0", ready1);
        end
        @(negedge clock);
        reset = 1'b1;
        do_req(0, 1, 0, 32'h24, 32'h0, F_W, d, m, lat);
        n_checks++;
        if (d !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL respond_write_kept: got %h expected 0badf00d", d);
        end
    endtask

    task automatic test_ws0;
        logic [31:0] d; logic m; int lat;
        do_req(1, 0, 1, 32'h40, 32'hCAFEF00D, F_W, d, m, lat);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL ws0_sw_latency: got %0d expected 1", lat);
        end
        do_req(1, 1, 0, 32'h40, 32'h0, F_W, d, m, lat);
        n_checks++;
        if (lat !== 1 || d !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL ws0_lw: got lat=%0d data=%h expected 1 cafef00d", lat, d);
        end
        abort_store(1, 32'h40);
        do_req(1, 1, 0, 32'h42, 32'h0, F_HU, d, m, lat);
        n_checks++;
        if (lat !== 1 || d !== 32'h0000CAFE) begin
            n_fail++;
            $display("FAIL ws0_abort: got lat=%0d data=%h expected 1 0000cafe", lat, d);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_reads();
        test_partial_writes();
        test_errors();
        test_wrap_and_both();
        test_reset_abort();
        test_ws0();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
